// File: rtl/pipe_pkg.sv
// Shared pipeline definitions.
// - Stall encoding (Stop/NoStop) and the reset level.
// - Default stall vector width.
// - Per-boundary payload layouts (field widths and offsets).
// - NOP bubble constants for each boundary.
package pipe_pkg;

    localparam logic Stop      = 1'b1;
    localparam logic NoStop    = 1'b0;
    localparam logic RstEnable = 1'b1;

    localparam int STALL_W_DEF = 6;

    // IF/ID: pc + instruction
    localparam int IF_ID_PC_W    = 32;
    localparam int IF_ID_INST_W  = 32;
    localparam int IF_ID_W       = IF_ID_PC_W + IF_ID_INST_W;
    localparam int IF_ID_INST_LO = 0;
    localparam int IF_ID_PC_LO   = IF_ID_INST_LO + IF_ID_INST_W;

    // ID/EX: aluop, alusel, wd, wreg, reg1, reg2 (MSB to LSB)
    localparam int ALUOP_W  = 8;
    localparam int ALUSEL_W = 3;
    localparam int WD_W     = 5;
    localparam int WREG_W   = 1;
    localparam int REG_W    = 32;
    localparam int ID_EX_W  = ALUOP_W + ALUSEL_W + WD_W + WREG_W + 2 * REG_W;
    localparam int ID_EX_REG2_LO   = 0;
    localparam int ID_EX_REG1_LO   = ID_EX_REG2_LO + REG_W;
    localparam int ID_EX_WREG_LO   = ID_EX_REG1_LO + REG_W;
    localparam int ID_EX_WD_LO     = ID_EX_WREG_LO + WREG_W;
    localparam int ID_EX_ALUSEL_LO = ID_EX_WD_LO + WD_W;
    localparam int ID_EX_ALUOP_LO  = ID_EX_ALUSEL_LO + ALUSEL_W;

    typedef struct packed {
        logic [ALUOP_W-1:0]  aluop;
        logic [ALUSEL_W-1:0] alusel;
        logic [WD_W-1:0]     wd;
        logic                wreg;
        logic [REG_W-1:0]    reg1;
        logic [REG_W-1:0]    reg2;
    } id_ex_t;

    // EX/MEM and MEM/WB: wd, wreg, wdata
    localparam int WB_W        = WD_W + WREG_W + REG_W;
    localparam int WB_WDATA_LO = 0;
    localparam int WB_WREG_LO  = WB_WDATA_LO + REG_W;
    localparam int WB_WD_LO    = WB_WREG_LO + WREG_W;

    // Bubbles: NOP op, NOP result type, NOP address, write disabled, zero data
    localparam logic [IF_ID_W-1:0] IF_ID_BUBBLE  = '0;
    localparam id_ex_t             ID_EX_BUBBLE  = '0;
    localparam logic [WB_W-1:0]    EX_MEM_BUBBLE = '0;
    localparam logic [WB_W-1:0]    MEM_WB_BUBBLE = '0;

endpackage

// File: rtl/pipe_stage_reg_sat_cnt.sv
// Saturating up-counter.
// Ports: clk, rst (sync, active high), clr (zero, below rst),
//        inc (count one, below clr), cnt (current value).
module pipe_sat_cnt
    import pipe_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst == RstEnable)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && (cnt != {CNT_W{1'b1}}))
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with flush and stall/bubble counters.
// Ports: clk, rst (sync, active high), stall (global stall vector),
//        flush, in_payload/in_valid (upstream), out_payload/out_valid
//        (registered, downstream), cnt_clr, stall_cnt, bubble_cnt.
// up = stall[STAGE], dn = stall[STAGE+1]. Priority: rst, flush, bubble
// (up stopped, dn running), capture (up running), hold (both stopped).
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                   PAYLOAD_W = 81,
    parameter int                   STALL_W   = STALL_W_DEF,
    parameter int                   STAGE     = 2,
    parameter logic [PAYLOAD_W-1:0] BUBBLE    = '0,
    parameter int                   CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [STALL_W-1:0]   stall,
    input  logic                 flush,
    input  logic [PAYLOAD_W-1:0] in_payload,
    input  logic                 in_valid,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic                 out_valid,
    input  logic                 cnt_clr,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     bubble_cnt
);

    logic up;
    logic dn;
    logic is_hold;
    logic is_bubble;

    assign up = stall[STAGE];
    assign dn = stall[STAGE+1];

    // Flush wins over both stall cases, so neither counter sees a flush cycle.
    assign is_hold   = !flush && (up == Stop) && (dn == Stop);
    assign is_bubble = !flush && (up == Stop) && (dn == NoStop);

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            out_payload <= BUBBLE;
            out_valid   <= 1'b0;
        end else if (flush || is_bubble) begin
            out_payload <= BUBBLE;
            out_valid   <= 1'b0;
        end else if (up == NoStop) begin
            // dn == Stop here is a controller error; capture anyway.
            out_payload <= in_payload;
            out_valid   <= in_valid;
        end
        // else hold: keep contents
    end

    pipe_sat_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (is_hold),
        .cnt (stall_cnt)
    );

    pipe_sat_cnt #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (is_bubble),
        .cnt (bubble_cnt)
    );

endmodule
